// File: rtl/vnu_ib_wr_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Package : vnu_ib_wr_pkg
// Purpose : Shared constants for the VNU IB-map write controller: FSM state
//           encodings, busy-status codes, bank write modes and a width helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package vnu_ib_wr_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE      = 2'd0;
  localparam logic [STATE_W-1:0] ST_ROM_FETCH = 2'd1;
  localparam logic [STATE_W-1:0] ST_RAM_LOAD  = 2'd2;
  localparam logic [STATE_W-1:0] ST_FINISH    = 2'd3;

  localparam logic [1:0] BUSY_IDLE = 2'b00;
  localparam logic [1:0] BUSY_LOAD = 2'b01;
  localparam logic [1:0] BUSY_FIN  = 2'b10;

  localparam int WR_MODE_PAR = 0;  // every bank written each cycle
  localparam int WR_MODE_RR  = 1;  // one bank per cycle, round-robin

  // Counter/address width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vnu_ib_wr_fsm_if.sv
`default_nettype none
// ============================================================================
// Interface : vnu_ib_wr_fsm_if
// Purpose   : Control/status bundle between decoding-process control (master)
//             and the IB-map write controller (slave).
// Signals   : iter_rqst, iter_termination (master -> slave);
//             rom_port_fetch, ram_mux_en, ram_write_en, bank_we, ram_waddr,
//             iter_update, v3ib_rom_rst, busy, load_done, load_abort,
//             iter_cnt, state (slave -> master)
// Revision  : 1.0 - initial release
// ============================================================================
interface vnu_ib_wr_fsm_if
  import vnu_ib_wr_pkg::*;
#(
  parameter int LOAD_CYCLE = 64,
  parameter int BANK_NUM   = 2,
  parameter int ITER_W     = 5
);
  localparam int AW = clog2_min1(LOAD_CYCLE);

  logic                iter_rqst;
  logic                iter_termination;
  logic                rom_port_fetch;
  logic                ram_mux_en;
  logic                ram_write_en;
  logic [BANK_NUM-1:0] bank_we;
  logic [AW-1:0]       ram_waddr;
  logic                iter_update;
  logic                v3ib_rom_rst;
  logic [1:0]          busy;
  logic                load_done;
  logic                load_abort;
  logic [ITER_W-1:0]   iter_cnt;
  logic [STATE_W-1:0]  state;

  modport master (
    output iter_rqst, iter_termination,
    input  rom_port_fetch, ram_mux_en, ram_write_en, bank_we, ram_waddr,
           iter_update, v3ib_rom_rst, busy, load_done, load_abort, iter_cnt,
           state
  );

  modport slave (
    input  iter_rqst, iter_termination,
    output rom_port_fetch, ram_mux_en, ram_write_en, bank_we, ram_waddr,
           iter_update, v3ib_rom_rst, busy, load_done, load_abort, iter_cnt,
           state
  );

endinterface
`default_nettype wire

// File: rtl/vnu_ib_wr_fsm_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : ib_wr_addr_gen
// Purpose : RAM write-address / bank-enable generator. Holds the write
//           counter, a bank-index counter and a row counter, and flags the
//           terminal write of a load.
// Ports   : clk, rst       - clock, synchronous active-high reset
//           clear          - zero all counters (held outside RAM_LOAD)
//           enable         - advance one write this cycle, gates outputs
//           mode           - 0 parallel banks, 1 round-robin banks
//           bank_we        - per-bank write enable
//           ram_waddr      - RAM write address
//           last           - current write is the final one of the load
// Revision: 1.0 - initial release
// ============================================================================
module ib_wr_addr_gen
  import vnu_ib_wr_pkg::*;
#(
  parameter  int LOAD_CYCLE = 64,
  parameter  int BANK_NUM   = 2,
  localparam int AW         = clog2_min1(LOAD_CYCLE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                enable,
  input  logic                mode,
  output logic [BANK_NUM-1:0] bank_we,
  output logic [AW-1:0]       ram_waddr,
  output logic                last
);

  localparam int TOTAL_RR = LOAD_CYCLE * BANK_NUM;
  localparam int CW       = clog2_min1(TOTAL_RR);
  localparam int BW       = clog2_min1(BANK_NUM);

  logic [CW-1:0] cnt_q,  cnt_d;
  logic [BW-1:0] bank_q, bank_d;
  logic [AW-1:0] row_q,  row_d;

  // Bank index and row are tracked explicitly rather than sliced/divided
  // from the write counter so non-power-of-2 bank counts wrap correctly.
  always_comb begin
    cnt_d  = cnt_q;
    bank_d = bank_q;
    row_d  = row_q;
    if (clear) begin
      cnt_d  = '0;
      bank_d = '0;
      row_d  = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CW'(1);
      if (bank_q == BW'(BANK_NUM - 1)) begin
        bank_d = '0;
        row_d  = row_q + AW'(1);
      end else begin
        bank_d = bank_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      bank_q <= '0;
      row_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      bank_q <= bank_d;
      row_q  <= row_d;
    end
  end

  always_comb begin
    last      = mode ? (cnt_q == CW'(TOTAL_RR - 1))
                     : (cnt_q == CW'(LOAD_CYCLE - 1));
    bank_we   = '0;
    ram_waddr = '0;
    if (enable) begin
      if (mode) begin
        for (int b = 0; b < BANK_NUM; b++) begin
          bank_we[b] = (bank_q == BW'(b));
        end
        ram_waddr = row_q;
      end else begin
        bank_we   = '1;
        ram_waddr = cnt_q[AW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vnu_ib_wr_fsm.sv
`default_nettype none
// ============================================================================
// Module  : vnu_ib_wr_fsm
// Purpose : VNU IB-map write controller. A rising iteration request walks
//           IDLE -> ROM_FETCH -> RAM_LOAD -> FINISH, fetching from the IB ROM
//           then loading the interleaved RAM banks, with done/abort pulses
//           and a saturating count of completed loads.
// Ports   : write_clk - sole clock
//           rst       - synchronous active-high reset
//           ib        - slave side of vnu_ib_wr_fsm_if (request/termination
//                       in; ROM/RAM controls, status, pulses, counter out)
// Revision: 1.0 - initial release
// ============================================================================
module vnu_ib_wr_fsm
  import vnu_ib_wr_pkg::*;
#(
  parameter int LOAD_CYCLE  = 64,
  parameter int BANK_NUM    = 2,
  parameter int ROM_LATENCY = 1,
  parameter int WR_MODE     = 0,
  parameter int ITER_W      = 5
) (
  input  logic              write_clk,
  input  logic              rst,
  vnu_ib_wr_fsm_if.slave    ib
);

  localparam int LW      = clog2_min1(ROM_LATENCY);
  localparam bit MODE_RR = (WR_MODE == WR_MODE_RR);

  logic [STATE_W-1:0] state_q, state_d;
  logic [LW-1:0]      lat_q, lat_d;
  logic [ITER_W-1:0]  iter_cnt_q, iter_cnt_d;
  logic               rqst_dly_q;
  logic               load_done_q, load_done_d;
  logic               load_abort_q, load_abort_d;

  logic               rqst_edge;
  logic               wr_last;
  logic               in_load;

  assign rqst_edge = ib.iter_rqst & ~rqst_dly_q;
  assign in_load   = (state_q == ST_RAM_LOAD);

  ib_wr_addr_gen #(
    .LOAD_CYCLE (LOAD_CYCLE),
    .BANK_NUM   (BANK_NUM)
  ) u_addr_gen (
    .clk       (write_clk),
    .rst       (rst),
    .clear     (~in_load),
    .enable    (in_load),
    .mode      (MODE_RR),
    .bank_we   (ib.bank_we),
    .ram_waddr (ib.ram_waddr),
    .last      (wr_last)
  );

  // State register and companion flops.
  always_ff @(posedge write_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      lat_q        <= '0;
      iter_cnt_q   <= '0;
      rqst_dly_q   <= 1'b0;
      load_done_q  <= 1'b0;
      load_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      iter_cnt_q   <= iter_cnt_d;
      rqst_dly_q   <= ib.iter_rqst;
      load_done_q  <= load_done_d;
      load_abort_q <= load_abort_d;
    end
  end

  // Next-state logic. Termination outranks the terminal write so a load
  // ending on the same cycle as termination reports abort, never done.
  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    iter_cnt_d   = iter_cnt_q;
    load_done_d  = 1'b0;
    load_abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rqst_edge && !ib.iter_termination) begin
          state_d = ST_ROM_FETCH;
          lat_d   = LW'(ROM_LATENCY - 1);
        end
      end
      ST_ROM_FETCH: begin
        if (ib.iter_termination) begin
          state_d      = ST_FINISH;
          load_abort_d = 1'b1;
        end else if (lat_q == '0) begin
          state_d = ST_RAM_LOAD;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      ST_RAM_LOAD: begin
        if (ib.iter_termination) begin
          state_d      = ST_FINISH;
          load_abort_d = 1'b1;
        end else if (wr_last) begin
          state_d     = ST_FINISH;
          load_done_d = 1'b1;
          if (iter_cnt_q != {ITER_W{1'b1}}) begin
            iter_cnt_d = iter_cnt_q + ITER_W'(1);
          end
        end
      end
      ST_FINISH: begin
        if (!ib.iter_rqst) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (ib.iter_termination) begin
      iter_cnt_d = '0;
    end
  end

  // Output decode from the current state.
  always_comb begin
    ib.rom_port_fetch = 1'b0;
    ib.ram_mux_en     = 1'b0;
    ib.iter_update    = 1'b0;
    ib.v3ib_rom_rst   = 1'b0;
    ib.busy           = BUSY_IDLE;
    case (state_q)
      ST_IDLE: begin
        ib.v3ib_rom_rst = 1'b1;
      end
      ST_ROM_FETCH: begin
        ib.rom_port_fetch = 1'b1;
        ib.iter_update    = 1'b1;
        ib.busy           = BUSY_LOAD;
      end
      ST_RAM_LOAD: begin
        ib.rom_port_fetch = 1'b1;
        ib.ram_mux_en     = 1'b1;
        ib.iter_update    = 1'b1;
        ib.busy           = BUSY_LOAD;
      end
      ST_FINISH: begin
        ib.v3ib_rom_rst = 1'b1;
        ib.busy         = BUSY_FIN;
      end
      default: begin
        ib.v3ib_rom_rst = 1'b1;
      end
    endcase
  end

  assign ib.ram_write_en = |ib.bank_we;
  assign ib.load_done    = load_done_q;
  assign ib.load_abort   = load_abort_q;
  assign ib.iter_cnt     = iter_cnt_q;
  assign ib.state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_vnu_ib_wr_fsm.sv
`default_nettype none
// ============================================================================
// Module  : tb_vnu_ib_wr_fsm
// Purpose : Self-checking bench for vnu_ib_wr_fsm. Instance A uses default
//           parameters; instance B is round-robin, 3 banks, 4 entries,
//           ROM latency 3, 2-bit iteration counter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vnu_ib_wr_fsm;

  typedef struct packed {int lc; int bn; int lat; int mode; int iw;} cfg_t;
  typedef struct packed {int st; int lat; int cnt; int ic; bit done; bit abort; bit rqd;} mdl_t;

  localparam cfg_t CFG_A = '{lc: 64, bn: 2, lat: 1, mode: 0, iw: 5};
  localparam cfg_t CFG_B = '{lc: 4,  bn: 3, lat: 3, mode: 1, iw: 2};

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  vnu_ib_wr_fsm_if #(.LOAD_CYCLE(64), .BANK_NUM(2), .ITER_W(5)) bus_a ();
  vnu_ib_wr_fsm_if #(.LOAD_CYCLE(4),  .BANK_NUM(3), .ITER_W(2)) bus_b ();

  vnu_ib_wr_fsm #(.LOAD_CYCLE(64), .BANK_NUM(2), .ROM_LATENCY(1), .WR_MODE(0), .ITER_W(5))
    dut_a (.write_clk(clk), .rst(rst_a), .ib(bus_a));
  vnu_ib_wr_fsm #(.LOAD_CYCLE(4), .BANK_NUM(3), .ROM_LATENCY(3), .WR_MODE(1), .ITER_W(2))
    dut_b (.write_clk(clk), .rst(rst_b), .ib(bus_b));

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [7:0]  hist_b[$];
  mdl_t ma, mb;

  bit a_rq, a_tm, a_rs, b_rq, b_tm, b_rs;
  int n_fetch_a, n_load_a, n_done_a, n_abort_a, last_wa_a;
  int n_fetch_b, n_load_b, n_done_b, n_abort_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: values visible after the clock edge that samples
  // the given inputs.
  function automatic mdl_t model_next(cfg_t c, mdl_t m, bit rq, bit tm, bit rs);
    mdl_t n = m;
    int total = (c.mode != 0) ? c.lc * c.bn : c.lc;
    n.done = 1'b0;
    n.abort = 1'b0;
    n.rqd = rq;
    if (rs) begin
      n = '0;
      return n;
    end
    case (m.st)
      0: if (rq && !m.rqd && !tm) begin n.st = 1; n.lat = c.lat - 1; end
      1: begin
        if (tm) begin n.st = 3; n.abort = 1'b1; end
        else if (m.lat == 0) begin n.st = 2; n.cnt = 0; end
        else n.lat = m.lat - 1;
      end
      2: begin
        if (tm) begin n.st = 3; n.abort = 1'b1; end
        else if (m.cnt == total - 1) begin
          n.st = 3;
          n.done = 1'b1;
          if (m.ic < (1 << c.iw) - 1) n.ic = m.ic + 1;
        end else n.cnt = m.cnt + 1;
      end
      default: if (!rq) n.st = 0;
    endcase
    if (tm) n.ic = 0;
    return n;
  endfunction

  function automatic logic [31:0] model_out(cfg_t c, mdl_t m);
    logic [1:0] st = 2'(m.st);
    logic [1:0] busy = (m.st == 3) ? 2'b10 : (m.st == 0) ? 2'b00 : 2'b01;
    bit act = (m.st == 1) || (m.st == 2);
    bit ld = (m.st == 2);
    int we = 0;
    int wa = 0;
    if (ld) begin
      if (c.mode != 0) begin we = 1 << (m.cnt % c.bn); wa = m.cnt / c.bn; end
      else begin we = (1 << c.bn) - 1; wa = m.cnt; end
    end
    return {1'b0, st, busy, act, ld, ld, act, !act, m.done, m.abort,
            8'(m.ic), 4'(we), 8'(wa)};
  endfunction

  function automatic logic [31:0] obs_a();
    return {1'b0, bus_a.state, bus_a.busy, bus_a.rom_port_fetch, bus_a.ram_mux_en,
            bus_a.ram_write_en, bus_a.iter_update, bus_a.v3ib_rom_rst, bus_a.load_done,
            bus_a.load_abort, 8'(bus_a.iter_cnt), 4'(bus_a.bank_we), 8'(bus_a.ram_waddr)};
  endfunction

  function automatic logic [31:0] obs_b();
    return {1'b0, bus_b.state, bus_b.busy, bus_b.rom_port_fetch, bus_b.ram_mux_en,
            bus_b.ram_write_en, bus_b.iter_update, bus_b.v3ib_rom_rst, bus_b.load_done,
            bus_b.load_abort, 8'(bus_b.iter_cnt), 4'(bus_b.bank_we), 8'(bus_b.ram_waddr)};
  endfunction

  task automatic clr_obs();
    n_fetch_a = 0; n_load_a = 0; n_done_a = 0; n_abort_a = 0; last_wa_a = -1;
    n_fetch_b = 0; n_load_b = 0; n_done_b = 0; n_abort_b = 0;
    hist_b.delete();
  endtask

  // One clock: drive held inputs, push expectations, sample and compare.
  task automatic tick();
    @(negedge clk);
    bus_a.iter_rqst = a_rq; bus_a.iter_termination = a_tm; rst_a = a_rs;
    bus_b.iter_rqst = b_rq; bus_b.iter_termination = b_tm; rst_b = b_rs;
    ma = model_next(CFG_A, ma, a_rq, a_tm, a_rs);
    mb = model_next(CFG_B, mb, b_rq, b_tm, b_rs);
    q_a.push_back(model_out(CFG_A, ma));
    q_b.push_back(model_out(CFG_B, mb));
    @(posedge clk);
    #1;
    check("outs_a", obs_a(), q_a.pop_front());
    check("outs_b", obs_b(), q_b.pop_front());
    if (bus_a.state == 2'd1) n_fetch_a++;
    if (bus_a.state == 2'd2) begin n_load_a++; last_wa_a = int'(bus_a.ram_waddr); end
    if (bus_a.load_done) n_done_a++;
    if (bus_a.load_abort) n_abort_a++;
    if (bus_b.state == 2'd1) n_fetch_b++;
    if (bus_b.state == 2'd2) begin
      n_load_b++;
      hist_b.push_back({bus_b.bank_we, 3'b000, bus_b.ram_waddr});
    end
    if (bus_b.load_done) n_done_b++;
    if (bus_b.load_abort) n_abort_b++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance A until it is in RAM_LOAD showing address wa (bounded).
  task automatic wait_a_addr(input int wa, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus_a.state == 2'd2 && int'(bus_a.ram_waddr) == wa) begin hit = 1'b1; break; end
      tick();
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ma = '0; mb = '0;
    a_rq = 0; a_tm = 0; a_rs = 1; b_rq = 0; b_tm = 0; b_rs = 1;
    bus_a.iter_rqst = 0; bus_a.iter_termination = 0; rst_a = 1;
    bus_b.iter_rqst = 0; bus_b.iter_termination = 0; rst_b = 1;
    clr_obs();

    // Reset state
    ticks(2);
    check("rst_state_a", 32'(bus_a.state), 32'd0);
    check("rst_romrst_a", 32'(bus_a.v3ib_rom_rst), 32'd1);
    check("rst_iter_cnt_b", 32'(bus_b.iter_cnt), 32'd0);
    a_rs = 0; b_rs = 0;

    // Default configuration: request rises at cycle 10 and stays high
    ticks(8);
    clr_obs();
    a_rq = 1;
    ticks(70);
    check("t1_fetch_cycles", 32'(n_fetch_a), 32'd1);
    check("t1_load_cycles", 32'(n_load_a), 32'd64);
    check("t1_last_waddr", 32'(last_wa_a), 32'd63);
    check("t1_done_pulses", 32'(n_done_a), 32'd1);
    check("t1_abort_pulses", 32'(n_abort_a), 32'd0);
    check("t1_iter_cnt", 32'(bus_a.iter_cnt), 32'd1);
    check("t1_finish_hold", 32'(bus_a.state), 32'd3);
    a_rq = 0;
    tick();
    check("t1_idle_after_drop", 32'(bus_a.state), 32'd0);

    // Round-robin configuration
    clr_obs();
    b_rq = 1;
    ticks(20);
    check("t2_fetch_cycles", 32'(n_fetch_b), 32'd3);
    check("t2_load_cycles", 32'(n_load_b), 32'd12);
    check("t2_done_pulses", 32'(n_done_b), 32'd1);
    if (hist_b.size() == 12) begin
      check("t2_we0", 32'(hist_b[0]), 32'h20);
      check("t2_we1", 32'(hist_b[1]), 32'h40);
      check("t2_we2", 32'(hist_b[2]), 32'h80);
      check("t2_we3", 32'(hist_b[3]), 32'h21);
      check("t2_we11", 32'(hist_b[11]), 32'h83);
    end else begin
      check("t2_hist_size", 32'(hist_b.size()), 32'd12);
    end
    b_rq = 0;
    tick();

    // Termination at write 20
    clr_obs();
    a_rq = 1;
    wait_a_addr(20, "t3_reach_w20");
    a_tm = 1;
    tick();
    a_tm = 0;
    check("t3_abort", 32'(bus_a.load_abort), 32'd1);
    check("t3_state", 32'(bus_a.state), 32'd3);
    check("t3_no_done", 32'(bus_a.load_done), 32'd0);
    check("t3_iter_cnt", 32'(bus_a.iter_cnt), 32'd0);
    check("t3_wen_off", 32'(bus_a.ram_write_en), 32'd0);
    a_rq = 0;
    ticks(2);

    // Termination coincident with the final write
    clr_obs();
    a_rq = 1;
    wait_a_addr(63, "t4_reach_w63");
    check("t4_w63_we", 32'(bus_a.bank_we), 32'h3);
    a_tm = 1;
    tick();
    a_tm = 0;
    check("t4_abort", 32'(bus_a.load_abort), 32'd1);
    check("t4_no_done", 32'(bus_a.load_done), 32'd0);
    check("t4_iter_cnt", 32'(bus_a.iter_cnt), 32'd0);
    a_rq = 0;
    ticks(2);

    // Reset mid-load, then restart
    a_rq = 1;
    wait_a_addr(30, "t5_reach_w30");
    a_rs = 1; a_rq = 0;
    tick();
    a_rs = 0;
    check("t5_state", 32'(bus_a.state), 32'd0);
    check("t5_romrst", 32'(bus_a.v3ib_rom_rst), 32'd1);
    check("t5_wen", 32'(bus_a.ram_write_en), 32'd0);
    check("t5_waddr", 32'(bus_a.ram_waddr), 32'd0);
    tick();
    a_rq = 1;
    wait_a_addr(0, "t5_restart_w0");
    a_rq = 0;
    ticks(70);

    // Saturating counter with ITER_W=2, extra edge during RAM_LOAD ignored
    b_tm = 1;
    tick();
    b_tm = 0;
    check("t6_cleared", 32'(bus_b.iter_cnt), 32'd0);
    clr_obs();
    for (int k = 0; k < 5; k++) begin
      bit seen = 1'b0;
      b_rq = 1;
      if (k == 0) begin
        for (int i = 0; i < 50 && bus_b.state != 2'd2; i++) tick();
        b_rq = 0;
        tick();
        b_rq = 1;
        tick();
      end
      for (int i = 0; i < 50; i++) begin
        if (bus_b.load_done) begin seen = 1'b1; break; end
        tick();
      end
      check("t6_done_seen", 32'(seen), 32'd1);
      check("t6_iter_cnt", 32'(bus_b.iter_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
      b_rq = 0;
      tick();
    end
    check("t6_fetch_cycles", 32'(n_fetch_b), 32'd15);
    check("t6_done_pulses", 32'(n_done_b), 32'd5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
